seq_alu_n: RTL and testbench

//  Parametrised, registered ALU for DE1-SoC lab datapaths.
//  - Unsigned ops: ADD, OR-reduce, AND-reduce, CONCAT and a multi-cycle shift-add MUL.
//  - Result register doubles as an accumulator.
//  - Fed by switch/key logic or a controller through a valid/ready input handshake.
//  - Result drives LEDR/HEX decoders.

---
 rtl/seq_alu_n_pkg.sv | 24 ++
 rtl/seq_alu_n_if.sv | 37 +++
 rtl/seq_alu_n_rca_n.sv | 27 ++
 rtl/seq_alu_n.sv | 153 +++++++++++++++
 tb/tb_seq_alu_n.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_n_pkg.sv
// Shared types for the sequential ALU.
//   alu_func_e : opcode encoding seen on the func bus (values 5..7 are undefined)
//   state_e    : controller state, also exported on the debug state signal
//   func_is_legal : 1 for any defined opcode
package seq_alu_n_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_ORR  = 3'd1,
    ALU_ANDR = 3'd2,
    ALU_CAT  = 3'd3,
    ALU_MUL  = 3'd4
  } alu_func_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  function automatic logic func_is_legal(input logic [2:0] f);
    return (f <= 3'd4);
  endfunction

endpackage

// File: rtl/seq_alu_n_if.sv
// Request/response bundle between a requester (switches, keys or a controller)
// and the ALU.
//   in_valid/in_ready : request handshake; a transfer happens on a rising clk
//                       edge where both are 1. The requester keeps in_valid and
//                       its operands stable until that edge; while in_ready is 0
//                       the request is simply not taken.
//   a, b, func, use_acc : operands and opcode, sampled only at the transfer edge
//   out_valid         : one-cycle pulse, result/illegal were just updated
//   result, illegal   : registered outputs, held between operations
//   dbg_state         : controller state for observation
// Modports: master = requester side, slave = ALU side.
interface seq_alu_n_if #(
  parameter int WIDTH = 4
);

  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             a;
  logic [WIDTH-1:0]             b;
  logic [2:0]                   func;
  logic                         use_acc;
  logic                         out_valid;
  logic [2*WIDTH-1:0]           result;
  logic                         illegal;
  seq_alu_n_pkg::state_e        dbg_state;

  modport master (
    output in_valid, a, b, func, use_acc,
    input  in_ready, out_valid, result, illegal, dbg_state
  );

  modport slave (
    input  in_valid, a, b, func, use_acc,
    output in_ready, out_valid, result, illegal, dbg_state
  );

endinterface

// File: rtl/seq_alu_n_rca_n.sv
// rca_n: parametrised ripple-carry adder built from full-adder cells.
//   a_i, b_i : WIDTH-bit addends
//   c_i      : carry in
//   s_o      : WIDTH-bit sum
//   c_o      : carry out of the top cell
module rca_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = carry[WIDTH];

endmodule

// File: rtl/seq_alu_n.sv
// seq_alu_n: registered unsigned ALU whose result register doubles as an
// accumulator. ADD/ORR/ANDR/CAT and undefined opcodes complete at the accepting
// edge; MUL is a shift-add over WIDTH further edges.
//   clk   : clock
//   reset : asynchronous, active-high, clears all state (aborts a running MUL)
//   bus   : seq_alu_n_if slave modport (handshake, operands, result, debug state)
module seq_alu_n
  import seq_alu_n_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  seq_alu_n_if.slave  bus
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e            state_q, state_d;
  logic [RW-1:0]     result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic              illegal_q, illegal_d;
  logic [RW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mlier_q, mlier_d;
  logic [RW-1:0]     partial_q, partial_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              in_ready;
  logic              accept;
  logic              mul_last;
  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH-1:0]  add_s;
  logic              add_co;
  logic [RW-1:0]     pp_addend;
  logic [RW-1:0]     pp_sum;
  logic              pp_co_unused;

  // Accumulator feedback uses the low half of the current result register.
  assign b_eff    = bus.use_acc ? result_q[WIDTH-1:0] : bus.b;
  assign accept   = bus.in_valid && in_ready;
  assign mul_last = (state_q == S_MUL) && (cnt_q == CW'(WIDTH - 1));

  rca_n #(.WIDTH(WIDTH)) u_add (
    .a_i (bus.a),
    .b_i (b_eff),
    .c_i (1'b0),
    .s_o (add_s),
    .c_o (add_co)
  );

  // The product of two WIDTH-bit values fits in RW bits, so this carry is
  // always 0 and is left unused.
  assign pp_addend = mlier_q[0] ? (mcand_q << cnt_q) : '0;

  rca_n #(.WIDTH(RW)) u_pp (
    .a_i (partial_q),
    .b_i (pp_addend),
    .c_i (1'b0),
    .s_o (pp_sum),
    .c_o (pp_co_unused)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept && (bus.func == ALU_MUL)) state_d = S_MUL;
      S_MUL:   if (mul_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_q == S_IDLE);
  end

  // Datapath next state
  always_comb begin
    result_d    = result_q;
    out_valid_d = 1'b0;
    illegal_d   = illegal_q;
    mcand_d     = mcand_q;
    mlier_d     = mlier_q;
    partial_d   = partial_q;
    cnt_d       = cnt_q;

    if (accept) begin
      if (bus.func == ALU_MUL) begin
        mcand_d   = RW'(bus.a);
        mlier_d   = b_eff;
        partial_d = '0;
        cnt_d     = '0;
      end else begin
        out_valid_d = 1'b1;
        illegal_d   = !func_is_legal(bus.func);
        case (bus.func)
          ALU_ADD:  result_d = RW'({add_co, add_s});
          ALU_ORR:  result_d = RW'(|{bus.a, b_eff});
          ALU_ANDR: result_d = RW'(&{bus.a, b_eff});
          ALU_CAT:  result_d = {bus.a, b_eff};
          default:  result_d = '0;
        endcase
      end
    end

    if (state_q == S_MUL) begin
      partial_d = pp_sum;
      mlier_d   = mlier_q >> 1;
      cnt_d     = cnt_q + 1'b1;
      // The result register is untouched until the final iteration.
      if (mul_last) begin
        result_d    = pp_sum;
        out_valid_d = 1'b1;
        illegal_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      mcand_q     <= '0;
      mlier_q     <= '0;
      partial_q   <= '0;
      cnt_q       <= '0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      mcand_q     <= mcand_d;
      mlier_q     <= mlier_d;
      partial_q   <= partial_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.illegal   = illegal_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seq_alu_n.sv
// Bench for seq_alu_n: a WIDTH=4 instance for all scenarios and a WIDTH=8
// instance for wide multiplies, checked against an arithmetic reference model.
module tb_seq_alu_n;
  import seq_alu_n_pkg::*;

  localparam int W   = 4;
  localparam int RW  = 2 * W;
  localparam int W8  = 8;
  localparam int RW8 = 2 * W8;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_alu_n_if #(.WIDTH(W))  bus4 ();
  seq_alu_n_if #(.WIDTH(W8)) bus8 ();

  seq_alu_n #(.WIDTH(W))  dut4 (.clk(clk), .reset(reset), .bus(bus4));
  seq_alu_n #(.WIDTH(W8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: what result/illegal should currently hold
  logic [RW-1:0] model_res;
  logic          model_ill;
  logic [RW-1:0] exp_q[$];

  function automatic logic [RW-1:0] ref_op(input int f, input int a, input int b);
    int top;
    top = (1 << W) - 1;
    case (f)
      0:       return RW'(a + b);
      1:       return ((a != 0) || (b != 0)) ? RW'(1) : RW'(0);
      2:       return ((a == top) && (b == top)) ? RW'(1) : RW'(0);
      3:       return RW'(a * (1 << W) + b);
      4:       return RW'(a * b);
      default: return RW'(0);
    endcase
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus4.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_res = '0;
    model_ill = 1'b0;
  endtask

  // Issue one op on the WIDTH=4 instance and check it to completion.
  task automatic do_op(input int f, input int a, input int b, input bit ua, input string tag);
    int b_eff, lat, cyc, busy;
    logic [RW-1:0] expv, hold;
    @(negedge clk);
    bus4.func = 3'(f); bus4.a = W'(a); bus4.b = W'(b); bus4.use_acc = ua;
    bus4.in_valid = 1'b1;
    cyc = 0;
    while (bus4.in_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (bus4.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s ready_timeout: in_ready=%b required 1", tag, bus4.in_ready);
    end
    b_eff = ua ? int'(model_res[W-1:0]) : b;
    exp_q.push_back(ref_op(f, a, b_eff));
    lat  = (f == 4) ? W : 0;
    hold = model_res;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    cyc = 0; busy = 0;
    while (bus4.out_valid !== 1'b1 && cyc < 20) begin
      if (bus4.in_ready === 1'b0) busy++;
      n_checks++;
      if (bus4.result !== hold) begin
        n_errors++;
        $display("FAIL %s result_mid_op: got %h required %h", tag, bus4.result, hold);
      end
      @(posedge clk); #1;
      cyc++;
    end
    expv = exp_q.pop_front();
    n_checks++;
    if (cyc !== lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d edges required %0d", tag, cyc, lat);
    end
    n_checks++;
    if (busy !== lat) begin
      n_errors++;
      $display("FAIL %s busy_cycles: got %0d required %0d", tag, busy, lat);
    end
    n_checks++;
    if (bus4.result !== expv) begin
      n_errors++;
      $display("FAIL %s result: got %h required %h", tag, bus4.result, expv);
    end
    n_checks++;
    if (bus4.illegal !== (f > 4)) begin
      n_errors++;
      $display("FAIL %s illegal: got %b required %b", tag, bus4.illegal, (f > 4));
    end
    n_checks++;
    if (bus4.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s ready_at_done: got %b required 1", tag, bus4.in_ready);
    end
    model_res = expv;
    model_ill = (f > 4);
    @(posedge clk); #1;
    n_checks++;
    if (bus4.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s out_valid_pulse: got %b required 0", tag, bus4.out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.func = '0; bus4.use_acc = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.func = '0; bus8.use_acc = 1'b0;
    #1;
    n_checks++;
    if (bus4.result !== '0 || bus4.out_valid !== 1'b0 || bus4.illegal !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got result=%h out_valid=%b illegal=%b required 0/0/0",
               bus4.result, bus4.out_valid, bus4.illegal);
    end
    n_checks++;
    if (bus4.in_ready !== 1'b1 || bus4.dbg_state !== S_IDLE) begin
      n_errors++;
      $display("FAIL reset_idle: got in_ready=%b state=%b required 1/IDLE",
               bus4.in_ready, bus4.dbg_state);
    end
    n_checks++;
    if (bus8.result !== '0) begin
      n_errors++;
      $display("FAIL reset_w8: got %h required 0", bus8.result);
    end
    apply_reset();
  endtask

  task automatic test_add();
    do_op(0, 15, 1, 1'b0, "add_F_1");
    n_checks++;
    if (model_res !== 8'h10) begin
      n_errors++;
      $display("FAIL add_F_1_const: got %h required 10", model_res);
    end
    do_op(0, 5, 3, 1'b0, "add_5_3");
  endtask

  task automatic test_reduce_cat();
    do_op(1, 0, 0, 1'b0, "orr_0_0");
    do_op(1, 0, 2, 1'b0, "orr_0_2");
    do_op(2, 15, 15, 1'b0, "andr_F_F");
    do_op(2, 15, 14, 1'b0, "andr_F_E");
    do_op(3, 10, 5, 1'b0, "cat_A_5");
    n_checks++;
    if (bus4.result !== 8'hA5) begin
      n_errors++;
      $display("FAIL cat_A_5_const: got %h required a5", bus4.result);
    end
  endtask

  task automatic test_mul();
    do_op(4, 15, 15, 1'b0, "mul_F_F");
    n_checks++;
    if (bus4.result !== 8'hE1) begin
      n_errors++;
      $display("FAIL mul_F_F_const: got %h required e1", bus4.result);
    end
    do_op(4, 0, 9, 1'b0, "mul_0_9");
    do_op(4, 6, 11, 1'b0, "mul_6_B");
  endtask

  task automatic test_accumulate();
    logic [RW-1:0] tab [4];
    tab = '{8'h03, 8'h06, 8'h09, 8'h0C};
    apply_reset();
    @(negedge clk);
    bus4.func = 3'd0; bus4.a = W'(3); bus4.b = W'(0); bus4.use_acc = 1'b1;
    bus4.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 3) bus4.in_valid = 1'b0;
      n_checks++;
      if (bus4.out_valid !== 1'b1 || bus4.result !== tab[i]) begin
        n_errors++;
        $display("FAIL acc_step%0d: got out_valid=%b result=%h required 1/%h",
                 i, bus4.out_valid, bus4.result, tab[i]);
      end
    end
    model_res = tab[3];
    @(posedge clk); #1;
    n_checks++;
    if (bus4.out_valid !== 1'b0 || bus4.result !== tab[3]) begin
      n_errors++;
      $display("FAIL acc_hold: got out_valid=%b result=%h required 0/%h",
               bus4.out_valid, bus4.result, tab[3]);
    end
  endtask

  task automatic test_mul_reset();
    int pulses;
    @(negedge clk);
    bus4.func = 3'd4; bus4.a = W'(7); bus4.b = W'(9); bus4.use_acc = 1'b0;
    bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus4.result !== '0 || bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_abort: got result=%h in_ready=%b out_valid=%b required 0/1/0",
               bus4.result, bus4.in_ready, bus4.out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    model_res = '0;
    model_ill = 1'b0;
    pulses = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (bus4.out_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_errors++;
      $display("FAIL mul_abort_no_valid: got %0d pulses required 0", pulses);
    end
    do_op(0, 1, 1, 1'b0, "add_after_abort");
    n_checks++;
    if (bus4.result !== 8'h02) begin
      n_errors++;
      $display("FAIL add_after_abort_const: got %h required 02", bus4.result);
    end
  endtask

  task automatic test_illegal();
    do_op(6, 15, 15, 1'b0, "illegal_6");
    do_op(0, 2, 4, 1'b0, "add_clears_illegal");
  endtask

  // MUL followed by an ADD request held through the busy period.
  task automatic test_back_to_back();
    int ma, mb, aa, ab, cyc;
    logic [RW-1:0] mexp, aexp;
    ma = $urandom_range(0, 15); mb = $urandom_range(0, 15);
    aa = $urandom_range(0, 15); ab = $urandom_range(0, 15);
    mexp = ref_op(4, ma, mb);
    aexp = ref_op(0, aa, ab);
    @(negedge clk);
    bus4.func = 3'd4; bus4.a = W'(ma); bus4.b = W'(mb); bus4.use_acc = 1'b0;
    bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.func = 3'd0; bus4.a = W'(aa); bus4.b = W'(ab);
    cyc = 0;
    while (bus4.out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc !== W || bus4.result !== mexp || bus4.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_mul: got edges=%0d result=%h in_ready=%b required %0d/%h/1",
               cyc, bus4.result, bus4.in_ready, W, mexp);
    end
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    n_checks++;
    if (bus4.out_valid !== 1'b1 || bus4.result !== aexp) begin
      n_errors++;
      $display("FAIL b2b_add: got out_valid=%b result=%h required 1/%h",
               bus4.out_valid, bus4.result, aexp);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus4.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_single_pulse: got %b required 0", bus4.out_valid);
    end
    model_res = aexp;
    model_ill = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_op($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
            1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic mul8(input int a, input int b);
    int cyc;
    logic [RW8-1:0] expv;
    expv = RW8'(a * b);
    @(negedge clk);
    bus8.func = 3'd4; bus8.a = W8'(a); bus8.b = W8'(b); bus8.use_acc = 1'b0;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    cyc = 0;
    while (bus8.out_valid !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc !== W8 || bus8.result !== expv) begin
      n_errors++;
      $display("FAIL mul8_%0d_%0d: got edges=%0d result=%h required %0d/%h",
               a, b, cyc, bus8.result, W8, expv);
    end
  endtask

  task automatic test_mul_w8();
    mul8(255, 255);
    for (int i = 0; i < 4; i++) mul8($urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  initial begin
    test_reset();
    test_add();
    test_reduce_cat();
    test_mul();
    test_accumulate();
    test_mul_reset();
    test_illegal();
    test_back_to_back();
    test_random();
    test_mul_w8();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
